jt900h_prefetch: RTL and testbench

- Instruction prefetch queue directly upstream of the microcode controller.
- Fetches 16-bit words from the bus into a byte FIFO and presents the head byte as `md`.
- Presents the next four bytes as `op` for immediates and displacements.
- Consumes 1/2/4 bytes per `inc_pc`, tracks `pc`, flushes and refetches on `jmp`, and raises `mem_busy` when a consume request exceeds the buffered bytes.

---
 rtl/jt900h_prefetch_pkg.sv | 23 ++
 rtl/jt900h_prefetch_if.sv | 10 +
 rtl/jt900h_pfq_buf.sv | 53 +++++
 rtl/jt900h_prefetch.sv | 103 ++++++++++
 tb/tb_jt900h_prefetch.sv | 278 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/jt900h_prefetch_pkg.sv
// Shared encodings for the 900H instruction prefetch queue.
package jt900h_prefetch_pkg;

    typedef logic [1:0] pf_state_t;

    localparam logic [1:0] FS_B = 2'd0;
    localparam logic [1:0] FS_W = 2'd1;
    localparam logic [1:0] FS_Q = 2'd2;

    localparam pf_state_t PF_IDLE = 2'd0;
    localparam pf_state_t PF_REQ  = 2'd1;
    localparam pf_state_t PF_KILL = 2'd2;

    // The reserved encoding behaves as a single-byte consume
    function automatic logic [2:0] fs_bytes(logic [1:0] fs);
        case (fs)
            FS_W:    return 3'd2;
            FS_Q:    return 3'd4;
            default: return 3'd1;
        endcase
    endfunction

endpackage

// File: rtl/jt900h_prefetch_if.sv
// 16-bit instruction read bus between the prefetch queue and memory.
interface jt900h_prefetch_if #(parameter int AW = 24);
    logic [AW-1:0] bus_addr;
    logic          bus_rd;
    logic [15:0]   bus_din;
    logic          bus_ok;

    modport master (output bus_addr, bus_rd, input bus_din, bus_ok);
    modport slave  (input bus_addr, bus_rd, output bus_din, bus_ok);
endinterface

// File: rtl/jt900h_pfq_buf.sv
// Circular byte buffer: push 1/2 bytes, pop 1/2/4, five-byte read window.
module jt900h_pfq_buf #(
    parameter int QD = 8,
    parameter int CW = $clog2(QD) + 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            cen,
    input  logic            flush,
    input  logic [1:0]      push_n,
    input  logic [15:0]     push_d,
    input  logic [2:0]      pop_n,
    output logic [CW-1:0]   count,
    output logic [CW-1:0]   cnt_nxt,
    output logic [4:0][7:0] win
);
    localparam int PW = $clog2(QD);

    logic [7:0]    mem [QD];
    logic [PW-1:0] rd, wr;

    assign cnt_nxt = flush ? '0 : count + CW'(push_n) - CW'(pop_n);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd    <= '0;
            wr    <= '0;
            count <= '0;
        end else if (cen) begin
            count <= cnt_nxt;
            if (flush) begin
                rd <= '0;
                wr <= '0;
            end else begin
                rd <= rd + PW'(pop_n);
                wr <= wr + PW'(push_n);
            end
        end
    end

    // Storage needs no reset: every read is masked by count
    always_ff @(posedge clk) begin
        if (cen && !flush) begin
            if (push_n != 2'd0) mem[wr] <= push_d[7:0];
            if (push_n == 2'd2) mem[wr + PW'(1)] <= push_d[15:8];
        end
    end

    for (genvar i = 0; i < 5; i++) begin : g_win
        assign win[i] = (CW'(i) < count) ? mem[rd + PW'(i)] : 8'h00;
    end

endmodule

// File: rtl/jt900h_prefetch.sv
// Instruction prefetch queue feeding the microcode controller: bus FSM and pc.
module jt900h_prefetch
    import jt900h_prefetch_pkg::*;
#(
    parameter int QD = 8,
    parameter int AW = 24
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 cen,
    input  logic                 inc_pc,
    input  logic [1:0]           fetch_sel,
    input  logic                 jmp,
    input  logic [AW-1:0]        jmp_addr,
    output logic [7:0]           md,
    output logic [31:0]          op,
    output logic [AW-1:0]        pc,
    output logic [$clog2(QD):0]  avail,
    output logic                 mem_busy,
    jt900h_prefetch_if.master    bus
);
    localparam int CW = $clog2(QD) + 1;

    pf_state_t      st;
    logic [AW-1:0]  faddr, baddr;
    logic           skip_lo;
    logic [2:0]     nbytes, pop_n;
    logic [1:0]     push_n;
    logic [15:0]    push_d;
    logic [CW-1:0]  cnt, cnt_nxt;
    logic [4:0][7:0] win;
    logic           take, room;

    assign nbytes   = fs_bytes(fetch_sel);
    assign mem_busy = inc_pc && (cnt < CW'(nbytes));
    assign take     = (st == PF_REQ) && bus.bus_ok && !jmp;
    assign push_n   = !take ? 2'd0 : (skip_lo ? 2'd1 : 2'd2);
    assign push_d   = skip_lo ? {8'h00, bus.bus_din[15:8]} : bus.bus_din;
    assign pop_n    = (inc_pc && !mem_busy && !jmp) ? nbytes : 3'd0;
    // Room for another word once this cycle's push and pop have landed
    assign room     = cnt_nxt <= CW'(QD - 2);

    jt900h_pfq_buf #(.QD(QD), .CW(CW)) u_buf (
        .clk     (clk),
        .rst_n   (rst_n),
        .cen     (cen),
        .flush   (jmp),
        .push_n  (push_n),
        .push_d  (push_d),
        .pop_n   (pop_n),
        .count   (cnt),
        .cnt_nxt (cnt_nxt),
        .win     (win)
    );

    assign md           = win[0];
    assign op           = {win[4], win[3], win[2], win[1]};
    assign avail        = cnt;
    assign bus.bus_addr = baddr;
    assign bus.bus_rd   = (st != PF_IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st      <= PF_IDLE;
            pc      <= '0;
            faddr   <= '0;
            baddr   <= '0;
            skip_lo <= 1'b0;
        end else if (cen) begin
            if (jmp) begin
                pc      <= jmp_addr;
                faddr   <= {jmp_addr[AW-1:1], 1'b0};
                skip_lo <= jmp_addr[0];
            end else if (pop_n != 3'd0) begin
                pc <= pc + AW'(nbytes);
            end
            case (st)
                PF_IDLE: if (!jmp && room) begin
                    st    <= PF_REQ;
                    baddr <= faddr;
                end
                PF_REQ: begin
                    if (bus.bus_ok) begin
                        if (!jmp) begin
                            faddr   <= faddr + AW'(2);
                            skip_lo <= 1'b0;
                            if (room) baddr <= faddr + AW'(2);
                            else      st    <= PF_IDLE;
                        end else begin
                            st <= PF_IDLE;
                        end
                    end else if (jmp) begin
                        st <= PF_KILL;
                    end
                end
                // Outstanding read must still complete; its data is dropped
                PF_KILL: if (bus.bus_ok) st <= PF_IDLE;
                default: st <= PF_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_jt900h_prefetch.sv
// Directed bench for jt900h_prefetch: vector table plus multi-cycle sequences.
module tb_jt900h_prefetch;
    localparam int AW = 24;
    localparam int QD = 8;

    logic          clk = 0, rst_n = 0, cen = 1, inc_pc = 0, jmp = 0;
    logic [1:0]    fetch_sel = 0;
    logic [AW-1:0] jmp_addr = 0;
    logic [7:0]    md;
    logic [31:0]   op;
    logic [AW-1:0] pc;
    logic [3:0]    avail;
    logic          mem_busy;

    jt900h_prefetch_if #(.AW(AW)) bus();

    jt900h_prefetch #(.QD(QD), .AW(AW)) dut (
        .clk(clk), .rst_n(rst_n), .cen(cen), .inc_pc(inc_pc),
        .fetch_sel(fetch_sel), .jmp(jmp), .jmp_addr(jmp_addr),
        .md(md), .op(op), .pc(pc), .avail(avail), .mem_busy(mem_busy),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int  n_cmp = 0, n_bad = 0;
    int  lat = 1, wcnt = 0;
    bit  hold = 1;
    logic [15:0] ovr [int];
    int  alog[$];

    typedef struct {
        logic        cen, inc;
        logic [1:0]  fs;
        logic        busy;
        logic [23:0] pc;
        logic [3:0]  av;
        logic [7:0]  md;
        logic [31:0] op;
    } vec_t;
    vec_t vt[7];

    // Default memory: each byte holds the low 8 bits of its own address
    function automatic logic [15:0] word_at(logic [AW-1:0] a);
        if (ovr.exists(int'(a))) return ovr[int'(a)];
        return {a[7:0] | 8'h01, a[7:0]};
    endfunction

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic bound_fail(string nm);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: timeout", nm);
    endtask

    task automatic cyc();
        @(posedge clk); #1;
        bus.bus_ok = 0;
        if (bus.bus_rd && !hold) begin
            if (wcnt >= lat) begin
                bus.bus_ok  = 1;
                bus.bus_din = word_at(bus.bus_addr);
                alog.push_back(int'(bus.bus_addr));
                wcnt = 0;
            end else wcnt++;
        end else wcnt = 0;
    endtask

    task automatic wait_avail(int k, string nm);
        int n = 0;
        while (int'(avail) < k && n < 60) begin cyc(); n++; end
        if (int'(avail) < k) bound_fail(nm);
    endtask

    task automatic wait_rd(string nm);
        int n = 0;
        while (!bus.bus_rd && n < 40) begin cyc(); n++; end
        if (!bus.bus_rd) bound_fail(nm);
    endtask

    task automatic do_jmp(logic [AW-1:0] a);
        jmp = 1; jmp_addr = a;
        cyc();
        jmp = 0;
    endtask

    initial begin
        vt[0] = '{1'b1, 1'b1, 2'd0, 1'b0, 24'h41, 4'd7, 8'h41, 32'h45444342};
        vt[1] = '{1'b0, 1'b1, 2'd1, 1'b0, 24'h41, 4'd7, 8'h41, 32'h45444342};
        vt[2] = '{1'b1, 1'b1, 2'd1, 1'b0, 24'h43, 4'd5, 8'h43, 32'h47464544};
        vt[3] = '{1'b1, 1'b1, 2'd3, 1'b0, 24'h44, 4'd4, 8'h44, 32'h00474645};
        vt[4] = '{1'b1, 1'b0, 2'd2, 1'b0, 24'h44, 4'd4, 8'h44, 32'h00474645};
        vt[5] = '{1'b1, 1'b1, 2'd2, 1'b0, 24'h48, 4'd0, 8'h00, 32'h00000000};
        vt[6] = '{1'b1, 1'b1, 2'd0, 1'b1, 24'h48, 4'd0, 8'h00, 32'h00000000};

        bus.bus_ok = 0; bus.bus_din = 0;
        repeat (2) @(posedge clk); #1;
        chk("rst_md", md, 0);
        chk("rst_op", op, 0);
        chk("rst_pc", pc, 0);
        chk("rst_avail", avail, 0);
        chk("rst_bus_rd", bus.bus_rd, 0);
        chk("rst_busy", mem_busy, 0);
        chk("rst_bus_addr", bus.bus_addr, 0);
        rst_n = 1;

        // Jump while the post-reset fetch is outstanding
        cyc();
        chk("post_rst_rd", bus.bus_rd, 1);
        do_jmp(24'h001000);
        chk("kill_rd_held", bus.bus_rd, 1);
        chk("kill_pc", pc, 24'h001000);
        bus.bus_ok = 1; bus.bus_din = 16'hFFFF;
        cyc();
        chk("kill_discard", avail, 0);
        ovr[32'h1000] = 16'h3412;
        ovr[32'h1002] = 16'h7856;
        alog.delete();
        hold = 0;
        wait_avail(4, "t1_fill");
        chk("t1_avail", avail, 4);
        chk("t1_md", md, 8'h12);
        chk("t1_op", op, 32'h00785634);
        chk("t1_addr0", alog.size() > 0 ? alog[0] : -1, 32'h1000);
        chk("t1_addr1", alog.size() > 1 ? alog[1] : -1, 32'h1002);
        wait_avail(8, "t1_full");
        repeat (3) begin cyc(); chk("full_no_rd", bus.bus_rd, 0); end

        // Odd jump target: first fetch yields only the high byte
        ovr.delete();
        ovr[32'h1000] = 16'hAABB;
        alog.delete();
        do_jmp(24'h001001);
        wait_avail(1, "t2_fill1");
        chk("t2_avail", avail, 1);
        chk("t2_md", md, 8'hAA);
        chk("t2_pc", pc, 24'h001001);
        wait_avail(3, "t2_fill3");
        chk("t2_addr0", alog.size() > 0 ? alog[0] : -1, 32'h1000);
        chk("t2_addr1", alog.size() > 1 ? alog[1] : -1, 32'h1002);
        chk("t2_op", op[15:0], 16'h0302);

        // Stall on a 4-byte consume with 3 buffered, then retry
        ovr.delete();
        lat = 3;
        do_jmp(24'h002001);
        wait_avail(3, "t3_fill");
        chk("t3_avail", avail, 3);
        inc_pc = 1; fetch_sel = 2'd2;
        #1;
        chk("t3_busy", mem_busy, 1);
        chk("t3_pc_hold", pc, 24'h002001);
        begin
            int n = 0;
            while (mem_busy && n < 20) begin
                cyc(); #1;
                if (mem_busy) chk("t3_stall_pc", pc, 24'h002001);
                n++;
            end
            if (mem_busy) bound_fail("t3_retry");
        end
        cyc();
        inc_pc = 0;
        chk("t3_pc", pc, 24'h002005);
        chk("t3_avail_after", avail, 1);
        chk("t3_md", md, 8'h05);

        // Fill across the end of the buffer
        lat = 1;
        do_jmp(24'h003001);
        wait_avail(7, "t4_fill");
        chk("t4_md0", md, 8'h01);
        repeat (3) begin cyc(); chk("t4_no_rd", bus.bus_rd, 0); end
        inc_pc = 1; fetch_sel = 2'd1;
        cyc();
        inc_pc = 0;
        chk("t4_rd_rise", bus.bus_rd, 1);
        chk("t4_pc2", pc, 24'h003003);
        chk("t4_avail5", avail, 5);
        wait_avail(7, "t4_refill");
        chk("t4_md", md, 8'h03);
        chk("t4_op", op, 32'h07060504);
        inc_pc = 1; fetch_sel = 2'd2;
        cyc();
        inc_pc = 0;
        chk("t4_pc4", pc, 24'h003007);
        chk("t4_avail3", avail, 3);
        chk("t4_md_wrap", md, 8'h07);
        chk("t4_op_wrap", op, 32'h00000908);

        // Vector table on a frozen, full queue at 0x40
        do_jmp(24'h000040);
        wait_avail(8, "tab_fill");
        hold = 1;
        for (int i = 0; i < 7; i++) begin
            cen = vt[i].cen; inc_pc = vt[i].inc; fetch_sel = vt[i].fs;
            #1;
            chk($sformatf("v%0d_busy", i), mem_busy, vt[i].busy);
            cyc();
            chk($sformatf("v%0d_pc", i), pc, vt[i].pc);
            chk($sformatf("v%0d_avail", i), avail, vt[i].av);
            chk($sformatf("v%0d_md", i), md, vt[i].md);
            chk($sformatf("v%0d_op", i), op, vt[i].op);
        end
        cen = 1; inc_pc = 0; fetch_sel = 0;

        // Jump while the read of 0x1004 is outstanding, retarget during kill
        hold = 0;
        ovr[32'h1004] = 16'hDEAD;
        do_jmp(24'h001000);
        begin
            int n = 0;
            while (!(bus.bus_rd && bus.bus_addr == 24'h001004) && n < 40) begin cyc(); n++; end
            if (!(bus.bus_rd && bus.bus_addr == 24'h001004)) bound_fail("t5_req1004");
        end
        hold = 1;
        do_jmp(24'h002100);
        chk("t5_kill_rd", bus.bus_rd, 1);
        chk("t5_kill_addr", bus.bus_addr, 24'h001004);
        chk("t5_flush", avail, 0);
        do_jmp(24'h002000);
        chk("t5_rejmp_pc", pc, 24'h002000);
        chk("t5_still_kill", bus.bus_rd, 1);
        bus.bus_ok = 1; bus.bus_din = 16'hDEAD;
        cyc();
        chk("t5_discard", avail, 0);
        chk("t5_idle", bus.bus_rd, 0);
        hold = 0;
        wait_rd("t5_refetch");
        chk("t5_new_addr", bus.bus_addr, 24'h002000);
        wait_avail(2, "t5_fill");
        chk("t5_md", md, 8'h00);
        chk("t5_op", op[7:0], 8'h01);

        // jmp, inc_pc and bus_ok together
        ovr.delete();
        do_jmp(24'h004000);
        begin
            int n = 0;
            do begin cyc(); n++; end while (!(bus.bus_ok && avail >= 2) && n < 40);
            if (!(bus.bus_ok && avail >= 2)) bound_fail("t6_setup");
        end
        jmp = 1; jmp_addr = 24'h005000; inc_pc = 1; fetch_sel = 2'd0;
        cyc();
        jmp = 0; inc_pc = 0;
        chk("t6_pc", pc, 24'h005000);
        chk("t6_avail", avail, 0);
        wait_rd("t6_refetch");
        chk("t6_addr", bus.bus_addr, 24'h005000);

        // Asynchronous reset in the middle of a request
        hold = 1;
        #2 rst_n = 0;
        #1;
        chk("t7_rd", bus.bus_rd, 0);
        chk("t7_pc", pc, 0);
        chk("t7_avail", avail, 0);
        chk("t7_addr", bus.bus_addr, 0);
        bus.bus_ok = 1; bus.bus_din = 16'h1234;
        repeat (2) @(posedge clk); #1;
        chk("t7_ok_ignored", avail, 0);
        rst_n = 1; bus.bus_ok = 0;
        cyc();
        chk("t7_pc_after", pc, 0);
        chk("t7_md_after", md, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
